// File: rtl/ped_request_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : ped_request_conditioner
//  Purpose  : Pedestrian push-button conditioning (sync, debounce, latched
//             request with holdoff) and 1 s timebase for the crossing controller.
//  Revision : 1.0 - initial release
// ============================================================================
module ped_request_conditioner #(
    parameter int TICK_DIV      = 50000000,
    parameter int DB_CYCLES     = 1000000,
    parameter int HOLDOFF_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    input  logic tick_clr,
    input  logic req_ack,
    output logic tick_1s,
    output logic req_pending,
    output logic wait_led
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int c_HOLD_W = (HOLDOFF_TICKS > 1) ? $clog2(HOLDOFF_TICKS) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLDOFF_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_SERVED  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser; r_vld marks when r_sync2 holds a real sample
    // ------------------------------------------------------------------
    logic       r_sync1;
    logic       r_sync2;
    logic [1:0] r_vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_vld   <= 2'b00;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Debounce and press detection
    // ------------------------------------------------------------------
    logic              r_stable;
    logic              r_stable_d;
    logic              r_armed;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              w_press_evt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_armed    <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_stable_d <= r_stable;
            if (r_sync2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_stable <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_DB_W'(1);
            end
            // A button held through reset must be seen released before it can request
            if (r_vld[1] && r_sync2 && r_stable) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_press_evt = r_stable_d & ~r_stable & r_armed;

    // ------------------------------------------------------------------
    // Timebase; a clear wins over the terminal count
    // ------------------------------------------------------------------
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                r_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (tick_clr) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (r_tick_cnt == c_TICK_LAST) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b1;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
            r_tick     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Request FSM with registered outputs
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                r_req_pending;
    logic                r_wait;
    logic                w_pending_nxt;
    logic                w_wait_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_hold        <= '0;
            r_req_pending <= 1'b0;
            r_wait        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hold        <= w_hold_nxt;
            r_req_pending <= w_pending_nxt;
            r_wait        <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_wait_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press_evt) begin
                    w_state_nxt = S_PENDING;
                    w_wait_nxt  = 1'b1;
                end
            end
            S_PENDING: begin
                if (req_ack) begin
                    w_state_nxt = S_SERVED;
                    w_hold_nxt  = '0;
                end else begin
                    w_wait_nxt = r_tick ? ~r_wait : r_wait;
                end
            end
            S_SERVED: begin
                if (r_tick) begin
                    if (r_hold == c_HOLD_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold + c_HOLD_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
        w_pending_nxt = (w_state_nxt == S_PENDING);
    end

    assign tick_1s     = r_tick;
    assign req_pending = r_req_pending;
    assign wait_led    = r_wait;

endmodule
`default_nettype wire

// File: tb/tb_ped_request_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ped_request_conditioner
//  Purpose  : Self-checking bench: vector table, directed corner sequences and
//             randomized button/ack/clear traffic against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ped_request_conditioner;

    localparam int TICK_DIV      = 10;
    localparam int DB_CYCLES     = 4;
    localparam int HOLDOFF_TICKS = 2;

    logic clk;
    logic reset;
    logic btn_n;
    logic tick_clr;
    logic req_ack;
    logic tick_1s;
    logic req_pending;
    logic wait_led;

    int n_cmp;
    int n_err;

    ped_request_conditioner #(
        .TICK_DIV      (TICK_DIV),
        .DB_CYCLES     (DB_CYCLES),
        .HOLDOFF_TICKS (HOLDOFF_TICKS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_n       (btn_n),
        .tick_clr    (tick_clr),
        .req_ack     (req_ack),
        .tick_1s     (tick_1s),
        .req_pending (req_pending),
        .wait_led    (wait_led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic btn_n;
        logic clr;
        logic ack;
        logic exp_tick;
        logic exp_req;
        logic exp_wait;
    } vec_t;

    vec_t vec [70];

    // ------------------------------------------------------------------
    // Reference model: edge index since reset release, history of raw
    // button samples, window-based debounce, modular-arithmetic timebase
    // ------------------------------------------------------------------
    typedef enum {M_IDLE, M_PEND, M_SERVED} phase_t;

    phase_t m_phase;
    int     m_e;
    int     m_last_clr;
    int     m_hold;
    logic   m_hist [$];
    logic   m_stable;
    logic   m_armed;
    logic   m_press;
    logic   m_tick;
    logic   m_wait;

    function automatic void model_reset();
        m_phase    = M_IDLE;
        m_e        = 0;
        m_last_clr = 0;
        m_hold     = 0;
        m_hist.delete();
        m_stable   = 1'b1;
        m_armed    = 1'b0;
        m_press    = 1'b0;
        m_tick     = 1'b0;
        m_wait     = 1'b0;
    endfunction

    // Raw button level captured at edge k (released before the first edge)
    function automatic logic samp(input int k);
        if (k >= 1) return m_hist[k-1];
        return 1'b1;
    endfunction

    function automatic void model_edge();
        logic flip;
        logic new_stable;
        logic arm;
        if (!reset) begin
            model_reset();
            return;
        end
        m_e = m_e + 1;
        m_hist.push_back(btn_n);
        case (m_phase)
            M_IDLE: begin
                if (m_press) begin
                    m_phase = M_PEND;
                    m_wait  = 1'b1;
                end
            end
            M_PEND: begin
                if (req_ack) begin
                    m_phase = M_SERVED;
                    m_hold  = 0;
                    m_wait  = 1'b0;
                end else if (m_tick) begin
                    m_wait = ~m_wait;
                end
            end
            default: begin
                if (m_tick) begin
                    m_hold = m_hold + 1;
                    if (m_hold == HOLDOFF_TICKS) m_phase = M_IDLE;
                end
            end
        endcase
        if (tick_clr) begin
            m_tick     = 1'b0;
            m_last_clr = m_e;
        end else begin
            m_tick = ((m_e - m_last_clr) % TICK_DIV) == 0;
        end
        // Level accepted once the last DB_CYCLES synchronised samples all disagree
        flip = 1'b1;
        for (int k = m_e - DB_CYCLES - 1; k <= m_e - 2; k++) begin
            if (samp(k) == m_stable) flip = 1'b0;
        end
        new_stable = flip ? ~m_stable : m_stable;
        arm        = m_armed | ((m_e >= 3) && samp(m_e - 2) && m_stable);
        m_press    = m_stable & ~new_stable & arm;
        m_stable   = new_stable;
        m_armed    = arm;
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("mdl_tick", tick_1s, m_tick);
        chk("mdl_req", req_pending, logic'(m_phase == M_PEND));
        chk("mdl_wait", wait_led, m_wait);
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_tick", tick_1s, 1'b0);
        chk("rst_req", req_pending, 1'b0);
        chk("rst_wait", wait_led, 1'b0);
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic press_latency(input string nm);
        btn_n = 1'b0;
        for (int k = 1; k <= DB_CYCLES + 3; k++) begin
            step();
            chk(nm, req_pending, logic'(k == DB_CYCLES + 3));
        end
    endtask

    int   seen;
    logic prev_tick;
    logic lvl;
    int   len;
    int   j;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        btn_n    = 1'b1;
        tick_clr = 1'b0;
        req_ack  = 1'b0;
        model_reset();

        // Two 35-edge timebase runs: free-running, then with a clear at edge 15
        for (int i = 0; i < 70; i++) begin
            j = (i % 35) + 1;
            vec[i].btn_n    = 1'b1;
            vec[i].ack      = 1'b0;
            vec[i].clr      = (i >= 35) && (j == 15);
            vec[i].exp_tick = (i >= 35) ? (j == 10 || j == 25 || j == 35)
                                        : (j == 10 || j == 20 || j == 30);
            vec[i].exp_req  = 1'b0;
            vec[i].exp_wait = 1'b0;
        end

        #2;
        for (int i = 0; i < 70; i++) begin
            if (i % 35 == 0) do_reset();
            btn_n    = vec[i].btn_n;
            tick_clr = vec[i].clr;
            req_ack  = vec[i].ack;
            step();
            chk("tbl_tick", tick_1s, vec[i].exp_tick);
            chk("tbl_req", req_pending, vec[i].exp_req);
            chk("tbl_wait", wait_led, vec[i].exp_wait);
        end
        tick_clr = 1'b0;
        req_ack  = 1'b0;

        // Short glitches alone never request
        btn_n = 1'b0; cycles(2);
        btn_n = 1'b1; cycles(1);
        btn_n = 1'b0; cycles(3);
        btn_n = 1'b1; cycles(10);
        chk("glitch_no_req", req_pending, 1'b0);

        // Bouncy press then clean low: request on the 7th edge
        btn_n = 1'b0; cycles(2);
        btn_n = 1'b1; cycles(1);
        btn_n = 1'b0; cycles(3);
        btn_n = 1'b1; cycles(2);
        btn_n = 1'b0; cycles(1);
        btn_n = 1'b1; cycles(1);
        press_latency("db_latency");

        // Second press while pending, then ack and holdoff
        cycles(3);
        btn_n = 1'b1; cycles(8);
        btn_n = 1'b0; cycles(10);
        chk("second_press_pending", req_pending, 1'b1);
        btn_n = 1'b1; cycles(8);
        chk("pending_hold", req_pending, 1'b1);
        req_ack = 1'b1; tick_clr = 1'b1; step();
        req_ack = 1'b0; tick_clr = 1'b0;
        chk("ack_clears", req_pending, 1'b0);
        btn_n = 1'b0; cycles(8);
        btn_n = 1'b1; cycles(8);
        chk("holdoff_ignore", req_pending, 1'b0);
        cycles(8);
        chk("idle_after_holdoff", req_pending, 1'b0);
        press_latency("press_after_holdoff");

        // Press event and ack in the same IDLE cycle
        btn_n = 1'b1; cycles(8);
        req_ack = 1'b1; tick_clr = 1'b1; step();
        req_ack = 1'b0; tick_clr = 1'b0;
        cycles(25);
        chk("idle_before_simul", req_pending, 1'b0);
        btn_n = 1'b0; cycles(DB_CYCLES + 2);
        req_ack = 1'b1; step();
        req_ack = 1'b0;
        chk("simul_req", req_pending, 1'b1);
        chk("wait_entry", wait_led, 1'b1);
        cycles(3);
        chk("simul_held", req_pending, 1'b1);

        // WAIT lamp toggles on each tick while pending
        seen = 0;
        for (int k = 0; k < 40 && seen < 3; k++) begin
            prev_tick = tick_1s;
            step();
            if (prev_tick) begin
                chk("wait_toggle", wait_led, logic'(seen % 2 == 0 ? 0 : 1));
                seen++;
            end
        end
        chk("wait_ticks_seen", logic'(seen == 3), 1'b1);
        chk("pending_until_ack", req_pending, 1'b1);
        req_ack = 1'b1; step();
        req_ack = 1'b0;
        chk("ack_req_low", req_pending, 1'b0);
        chk("ack_wait_low", wait_led, 1'b0);

        // Reset mid-PENDING with the button held low
        btn_n = 1'b1; cycles(30);
        chk("idle_before_rst", req_pending, 1'b0);
        btn_n = 1'b0; cycles(DB_CYCLES + 3);
        chk("pending_before_rst", req_pending, 1'b1);
        cycles(2);
        do_reset();
        cycles(20);
        chk("held_no_req", req_pending, 1'b0);
        btn_n = 1'b1; cycles(10);
        press_latency("repress_after_rst");

        // Randomized traffic against the model
        for (int r = 0; r < 400; r++) begin
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 12));
            for (int c = 0; c < len; c++) begin
                btn_n    = lvl;
                req_ack  = ($urandom_range(0, 15) == 0);
                tick_clr = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 799) == 0) begin
                    reset = 1'b0;
                    model_reset();
                    step();
                    reset = 1'b1;
                end
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
